// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with a two-entry (main + skid) buffer.
// The main entry drives the MEM stage; the skid entry catches a beat that
// arrives while the main entry is stalled, so in_ready depends only on state.
module ex_mem_pipe #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CTRL_W  = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_res,
  input  logic [DATA_W-1:0]  in_srcb,
  input  logic [RADDR_W-1:0] in_raddr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_res,
  output logic [DATA_W-1:0]  out_srcb,
  output logic [RADDR_W-1:0] out_raddr,
  output logic [CNT_W-1:0]   stall_cnt
);

  // main entry
  logic               m_valid;
  logic [CTRL_W-1:0]  m_ctrl;
  logic [DATA_W-1:0]  m_res;
  logic [DATA_W-1:0]  m_srcb;
  logic [RADDR_W-1:0] m_raddr;

  // skid entry
  logic               s_valid;
  logic [CTRL_W-1:0]  s_ctrl;
  logic [DATA_W-1:0]  s_res;
  logic [DATA_W-1:0]  s_srcb;
  logic [RADDR_W-1:0] s_raddr;

  logic accept;
  logic m_adv;
  logic stalled;

  assign in_ready  = ~s_valid;
  assign accept    = in_valid & ~s_valid;
  assign m_adv     = ~m_valid | out_ready;
  assign stalled   = m_valid & ~out_ready;

  assign out_valid = m_valid;
  assign out_ctrl  = m_ctrl & {CTRL_W{m_valid}};
  assign out_res   = m_res;
  assign out_srcb  = m_srcb;
  assign out_raddr = m_raddr;

  // Move beats EX -> skid/main -> MEM; flush kills everything, including the incoming beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      m_res   <= '0;
      m_srcb  <= '0;
      m_raddr <= '0;
      s_valid <= 1'b0;
      s_ctrl  <= '0;
      s_res   <= '0;
      s_srcb  <= '0;
      s_raddr <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (m_adv) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        m_ctrl  <= s_ctrl;
        m_res   <= s_res;
        m_srcb  <= s_srcb;
        m_raddr <= s_raddr;
        s_valid <= accept;
        if (accept) begin
          s_ctrl  <= in_ctrl;
          s_res   <= in_res;
          s_srcb  <= in_srcb;
          s_raddr <= in_raddr;
        end
      end else if (accept) begin
        m_valid <= 1'b1;
        m_ctrl  <= in_ctrl;
        m_res   <= in_res;
        m_srcb  <= in_srcb;
        m_raddr <= in_raddr;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      s_valid <= 1'b1;
      s_ctrl  <= in_ctrl;
      s_res   <= in_res;
      s_srcb  <= in_srcb;
      s_raddr <= in_raddr;
    end
  end

  // Count stalled cycles, saturating at all-ones; flush leaves the count alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stalled && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: a vector table for streaming, backpressure,
// flush and bubble gating, plus hand sequences for saturation and async reset.
module tb_ex_mem_pipe;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 3;
  localparam int NW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_res;
  logic [DW-1:0] in_srcb;
  logic [RW-1:0] in_raddr;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_res;
  logic [DW-1:0] out_srcb;
  logic [RW-1:0] out_raddr;
  logic [NW-1:0] stall_cnt;

  int nChecks = 0;
  int nFails  = 0;

  ex_mem_pipe #(.DATA_W(DW), .RADDR_W(RW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_res(in_res), .in_srcb(in_srcb), .in_raddr(in_raddr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_res(out_res), .out_srcb(out_srcb), .out_raddr(out_raddr),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [CW-1:0] ictrl;
    logic [DW-1:0] ires;
    logic [DW-1:0] isrcb;
    logic [RW-1:0] iraddr;
    logic          fl;
    logic          ordy;
    logic          eov;
    logic [CW-1:0] ectrl;
    logic [DW-1:0] eres;
    logic [DW-1:0] esrcb;
    logic [RW-1:0] eraddr;
    logic          eir;
    logic [NW-1:0] ecnt;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic iv, input logic [CW-1:0] ictrl,
                              input logic [DW-1:0] ires, input logic [RW-1:0] iraddr,
                              input logic fl, input logic ordy,
                              input logic eov, input logic [CW-1:0] ectrl,
                              input logic [DW-1:0] eres, input logic [RW-1:0] eraddr,
                              input logic eir, input logic [NW-1:0] ecnt);
    vec_t v;
    v.iv = iv; v.ictrl = ictrl; v.ires = ires; v.isrcb = ires ^ 32'hA5A5_0000;
    v.iraddr = iraddr; v.fl = fl; v.ordy = ordy;
    v.eov = eov; v.ectrl = ectrl; v.eres = eres; v.esrcb = eres ^ 32'hA5A5_0000;
    v.eraddr = eraddr; v.eir = eir; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    in_valid  = v.iv;
    in_ctrl   = v.ictrl;
    in_res    = v.ires;
    in_srcb   = v.isrcb;
    in_raddr  = v.iraddr;
    flush     = v.fl;
    out_ready = v.ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    string p;
    p = $sformatf("vec%0d", idx);
    cmp({p, ".out_valid"}, DW'(out_valid), DW'(v.eov));
    cmp({p, ".out_ctrl"},  DW'(out_ctrl),  DW'(v.ectrl));
    cmp({p, ".in_ready"},  DW'(in_ready),  DW'(v.eir));
    cmp({p, ".stall_cnt"}, DW'(stall_cnt), DW'(v.ecnt));
    if (v.eov) begin
      cmp({p, ".out_res"},   out_res,          v.eres);
      cmp({p, ".out_srcb"},  out_srcb,         v.esrcb);
      cmp({p, ".out_raddr"}, DW'(out_raddr),   DW'(v.eraddr));
    end
  endtask

  task automatic idleInputs();
    in_valid = 1'b0; in_ctrl = '0; in_res = '0; in_srcb = '0; in_raddr = '0;
    flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset.out_valid", DW'(out_valid), 0);
    cmp("reset.out_ctrl",  DW'(out_ctrl),  0);
    cmp("reset.in_ready",  DW'(in_ready),  1);
    cmp("reset.stall_cnt", DW'(stall_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    //                 iv ictrl   ires   ra  fl or  eov ectrl  eres   era eir cnt
    // streaming
    vecs[0]  = mk(1, 3'b001, 32'h10, 3,  0, 1,  1, 3'b001, 32'h10, 3,  1, 0);
    vecs[1]  = mk(1, 3'b011, 32'h20, 4,  0, 1,  1, 3'b011, 32'h20, 4,  1, 0);
    // bubbles with stale control
    vecs[2]  = mk(0, 3'b111, 32'h99, 1,  0, 1,  0, 3'b000, 32'h0,  0,  1, 0);
    vecs[3]  = mk(0, 3'b111, 32'h99, 1,  0, 0,  0, 3'b000, 32'h0,  0,  1, 0);
    // backpressure: A in M, B into skid, C held off, then drain in order
    vecs[4]  = mk(1, 3'b001, 32'h30, 5,  0, 0,  1, 3'b001, 32'h30, 5,  1, 0);
    vecs[5]  = mk(1, 3'b100, 32'h40, 6,  0, 0,  1, 3'b001, 32'h30, 5,  0, 1);
    vecs[6]  = mk(1, 3'b011, 32'h50, 7,  0, 0,  1, 3'b001, 32'h30, 5,  0, 2);
    vecs[7]  = mk(1, 3'b011, 32'h50, 7,  0, 1,  1, 3'b100, 32'h40, 6,  1, 2);
    vecs[8]  = mk(1, 3'b011, 32'h50, 7,  0, 1,  1, 3'b011, 32'h50, 7,  1, 2);
    vecs[9]  = mk(0, 3'b000, 32'h0,  0,  0, 1,  0, 3'b000, 32'h0,  0,  1, 2);
    // flush with both entries full and a beat offered
    vecs[10] = mk(1, 3'b001, 32'h60, 8,  0, 0,  1, 3'b001, 32'h60, 8,  1, 2);
    vecs[11] = mk(1, 3'b010, 32'h70, 9,  0, 0,  1, 3'b001, 32'h60, 8,  0, 3);
    vecs[12] = mk(1, 3'b111, 32'h80, 10, 1, 0,  0, 3'b000, 32'h0,  0,  1, 4);
    vecs[13] = mk(0, 3'b111, 32'h0,  0,  0, 1,  0, 3'b000, 32'h0,  0,  1, 4);
    // flush kills a beat accepted into an empty pipe
    vecs[14] = mk(1, 3'b101, 32'h90, 11, 1, 1,  0, 3'b000, 32'h0,  0,  1, 4);
    vecs[15] = mk(0, 3'b101, 32'h0,  0,  0, 1,  0, 3'b000, 32'h0,  0,  1, 4);

    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // saturation: hold one beat under backpressure for 20 cycles
    doReset();
    in_valid = 1'b1; in_ctrl = 3'b001; in_res = 32'hC0; in_raddr = 5'd12; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cmp("sat.start", DW'(stall_cnt), 0);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      cmp($sformatf("sat.cnt%0d", i), DW'(stall_cnt), DW'((i > 15) ? 15 : i));
    end
    cmp("sat.out_valid", DW'(out_valid), 1);

    // async reset between edges with two beats held
    doReset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 3'b011; in_res = 32'hD0; in_raddr = 5'd13;
    @(posedge clk); #1;
    in_ctrl = 3'b101; in_res = 32'hE0; in_raddr = 5'd14;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cmp("arst.pre_in_ready", DW'(in_ready), 0);
    cmp("arst.pre_cnt", DW'(stall_cnt), 1);
    #2 rst = 1'b0;
    #1;
    cmp("arst.out_valid", DW'(out_valid), 0);
    cmp("arst.out_ctrl",  DW'(out_ctrl),  0);
    cmp("arst.stall_cnt", DW'(stall_cnt), 0);
    cmp("arst.in_ready",  DW'(in_ready),  1);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cmp($sformatf("arst.post%0d.out_valid", i), DW'(out_valid), 0);
      cmp($sformatf("arst.post%0d.out_ctrl", i),  DW'(out_ctrl),  0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 Parameter DATA_W, default 32, width of ALU result and store-data fields.
REQ-002 Parameter RADDR_W, default 5, width of destination register address.
REQ-003 Parameter CTRL_W, default 3, width of control bundle (bit0 WREG, bit1 M2REG, bit2 WMEM at default).
REQ-004 Parameter CNT_W, default 16, width of stall counter.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset; state clears immediately while rst=0.
REQ-007 in_valid  in  1  EX stage presents a valid instruction.
REQ-008 in_ready  out  1  block can accept a beat this cycle.
REQ-009 in_ctrl  in  CTRL_W  control bundle from EX.
REQ-010 in_res  in  DATA_W  ALU result (memory address / writeback value).
REQ-011 in_srcb  in  DATA_W  store data.
REQ-012 in_raddr  in  RADDR_W  destination register address.
REQ-013 flush  in  1  kill all held and incoming beats.
REQ-014 out_valid  out  1  MEM stage beat valid.
REQ-015 out_ready  in  1  MEM stage consumes beat.
REQ-016 out_ctrl, out_res, out_srcb, out_raddr  out  CTRL_W/DATA_W/DATA_W/RADDR_W  payload to MEM stage.
REQ-017 stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-018 Storage SHALL be two entries: main (M) and skid (S), each with valid bit and full payload.
REQ-019 in_ready SHALL equal NOT S.valid, driven from state only (no combinational path from out_ready).
REQ-020 Beat accepted SHALL mean in_valid=1 and in_ready=1 at rising edge.
REQ-021 out_valid SHALL equal M.valid; out_res, out_srcb, out_raddr SHALL equal M payload.
REQ-022 out_ctrl SHALL equal M.ctrl ANDed with M.valid, so write enables are 0 for bubbles.
REQ-023 M SHALL advance when M.valid=0 or out_ready=1: load S if S.valid, else load accepted beat, else become invalid.
REQ-024 When M holds (M.valid=1, out_ready=0) and a beat is accepted, beat SHALL load S.
REQ-025 When M loads from S and a beat is accepted same cycle, beat SHALL load S (S stays valid).
REQ-026 Beats SHALL leave in acceptance order; none duplicated or dropped except by flush.
REQ-027 Latency SHALL be 1 cycle: beat accepted at edge N appears on outputs after edge N when M was free.
REQ-028 flush=1 at an edge SHALL clear M.valid and S.valid and discard any beat accepted that cycle; flush has priority over all moves.
REQ-029 Payload registers of invalid entries MAY hold stale data; only out_ctrl gating is observable.
REQ-030 stall_cnt SHALL increment by 1 on each edge with out_valid=1 and out_ready=0, saturating at all-ones, never wrapping; flush does not clear it.
REQ-031 Full (S.valid=1) SHALL deassert in_ready; in_valid then has no effect.

Reset
REQ-032 rst=0 SHALL asynchronously clear M.valid, S.valid, all payload registers to 0, and stall_cnt to 0.
REQ-033 During and after reset until first accepted beat: out_valid=0, out_ctrl=0, in_ready=1.
REQ-034 Reset asserted mid-operation SHALL discard held beats without emitting them.

Verification
REQ-035 Streaming: out_ready=1, beats A(res=0x10,raddr=3,ctrl=3'b001) then B(res=0x20) on consecutive cycles -> A out one edge later, B next edge, in_ready constant 1.
REQ-036 Backpressure: out_ready=0 with A in M, accept B -> B in S, in_ready=0, C held by EX; release out_ready -> A, B, C in order, stall_cnt = stalled cycles.
REQ-037 Flush: M and S valid, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, incoming beat never emitted.
REQ-038 Saturation: CNT_W=4, out_ready=0 for 20 cycles with valid M -> stall_cnt stops at 15.
REQ-039 Async reset: drop rst=0 between edges with two beats held -> outputs and stall_cnt 0 immediately, no beat emitted after rst=1.
REQ-040 Bubble gating: in_valid=0 stream with stale in_ctrl=3'b111 -> out_ctrl stays 3'b000.
